// File: rtl/ahb_dm_slave.sv
// ahb_dm_slave
// AHB-lite slave for the data-memory region. Accepts single writes and
// pipelined reads from the CPU data-memory master and drives a single-port
// synchronous SRAM macro. Every transfer gets a configurable number of wait
// states. A misaligned access gets a two-cycle ERROR response and never
// touches the SRAM.
//
// Parameters:
//   ADDR_WORDS_BITS  SRAM word-address width (word index = HADDR[ADDR_WORDS_BITS+1:2])
//   WAIT_STATES      extra data-phase cycles per transfer (0..7)
//
// Ports:
//   HCLK       in   bus clock, rising edge
//   rst        in   asynchronous active-high reset
//   HSEL       in   slave select
//   HTRANS     in   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HADDR      in   address-phase address
//   HWRITE     in   1 = write
//   HWDATA     in   write data (data phase)
//   HREADY     in   global bus ready
//   HREADYOUT  out  slave ready, low stretches the data phase
//   HRESP      out  00 OKAY, 01 ERROR
//   HRDATA     out  read data, non-zero only in the last cycle of a read
//   SRAM_CS    out  SRAM chip select
//   SRAM_WE    out  SRAM write enable (qualified by SRAM_CS)
//   SRAM_A     out  SRAM word address
//   SRAM_DI    out  SRAM write data
//   SRAM_DO    in   SRAM read data, one cycle after the read strobe

module ahb_dm_slave #(
    parameter int ADDR_WORDS_BITS = 14,
    parameter int WAIT_STATES     = 1
) (
    input  logic                       HCLK,
    input  logic                       rst,
    input  logic                       HSEL,
    input  logic [1:0]                 HTRANS,
    input  logic [31:0]                HADDR,
    input  logic                       HWRITE,
    input  logic [31:0]                HWDATA,
    input  logic                       HREADY,
    output logic                       HREADYOUT,
    output logic [1:0]                 HRESP,
    output logic [31:0]                HRDATA,
    output logic                       SRAM_CS,
    output logic                       SRAM_WE,
    output logic [ADDR_WORDS_BITS-1:0] SRAM_A,
    output logic [31:0]                SRAM_DI,
    input  logic [31:0]                SRAM_DO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // A read always needs at least one wait cycle, because the SRAM returns
    // data one cycle after the strobe, and the strobe must come before LAST.
    localparam logic [2:0] WR_LOAD = 3'(WAIT_STATES);
    localparam logic [2:0] RD_LOAD = (WAIT_STATES == 0) ? 3'd1 : 3'(WAIT_STATES);

    state_t                     state;
    logic [2:0]                 cnt;
    logic [ADDR_WORDS_BITS-1:0] idx;
    logic                       wr;

    logic accept;
    logic misaligned;
    logic rd_strobe;
    logic wr_strobe;

    // Address bits above the SRAM index select the region and are decoded
    // upstream, so this block deliberately ignores them.
    logic unused_addr_bits;
    assign unused_addr_bits = ^HADDR[31:ADDR_WORDS_BITS+2];

    // A new address phase is taken only while the slave itself is ready, so
    // a transfer is never accepted while a WAIT or ERR1 cycle is in progress.
    assign accept = HSEL && HTRANS[1] && HREADY &&
                    ((state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2));
    assign misaligned = (HADDR[1:0] != 2'b00);

    // Transfer sequencing. IDLE, LAST and ERR2 behave the same way: each
    // starts a new data phase on accept, otherwise the slave drops to IDLE.
    // WAIT counts the remaining wait cycles down to LAST.
    always_ff @(posedge HCLK or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            idx   <= '0;
            wr    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_LAST, ST_ERR2: begin
                    if (accept) begin
                        idx <= HADDR[ADDR_WORDS_BITS+1:2];
                        wr  <= HWRITE;
                        if (misaligned) begin
                            state <= ST_ERR1;
                            cnt   <= 3'd0;
                        end else if (HWRITE) begin
                            if (WR_LOAD == 3'd0) begin
                                state <= ST_LAST;
                                cnt   <= 3'd0;
                            end else begin
                                state <= ST_WAIT;
                                cnt   <= WR_LOAD;
                            end
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= RD_LOAD;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= ST_LAST;
                    end
                end
                ST_ERR1: begin
                    state <= ST_ERR2;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The read strobe fires in the final WAIT cycle so that SRAM_DO is valid
    // in LAST. The write strobe fires in LAST, where HWDATA is guaranteed
    // valid, which also puts it ahead of any pipelined read of the same word.
    assign rd_strobe = (state == ST_WAIT) && !wr && (cnt == 3'd1);
    assign wr_strobe = (state == ST_LAST) && wr;

    // Bus response and SRAM controls decoded from state and latched fields.
    always_comb begin
        HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
        HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
        HRDATA    = ((state == ST_LAST) && !wr) ? SRAM_DO : 32'd0;
        SRAM_CS   = rd_strobe || wr_strobe;
        SRAM_WE   = wr_strobe;
        SRAM_A    = (rd_strobe || wr_strobe) ? idx : '0;
        SRAM_DI   = wr_strobe ? HWDATA : 32'd0;
    end

endmodule

// File: tb/tb_ahb_dm_slave.sv
// tb_ahb_dm_slave
// Two instances of ahb_dm_slave (WAIT_STATES=1 and WAIT_STATES=0) share one
// driven bus. Only the selected instance sees HSEL. The stimulus issues
// transfers and pushes the response it expects, computed from a word-level
// memory model, into a per-instance queue. A monitor pops one entry for
// each accepted address phase and checks the data phase it observes: the
// length, HRESP, HRDATA and the SRAM strobes.

module tb_ahb_dm_slave;

    typedef struct {
        int          kind;   // 0 write, 1 read, 2 misaligned
        logic [13:0] idx;
        logic [31:0] data;
        int          len;
    } exp_t;

    logic        HCLK;
    logic        rst;
    logic        hsel_drv;
    logic        dut_sel;
    logic        force_low;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;

    logic [1:0]  hsel;
    logic [1:0]  hready;
    logic [1:0]  hreadyout;
    logic [1:0]  sram_cs;
    logic [1:0]  sram_we;
    logic [1:0]  hresp  [2];
    logic [31:0] hrdata [2];
    logic [13:0] sram_a [2];
    logic [31:0] sram_di[2];
    logic [31:0] sram_do[2];

    logic [31:0] sram0 [0:16383];
    logic [31:0] sram1 [0:16383];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ref_mem [int];

    int n_checks;
    int n_pass;

    // Monitor bookkeeping, one slot per instance.
    logic in_phase[2];
    int   cyc[2];
    exp_t cur[2];
    int   wr_seen[2];
    int   rd_seen[2];
    int   wr_c[2];
    int   rd_c[2];
    logic [13:0] wr_a[2];
    logic [13:0] rd_a[2];
    logic [31:0] wr_d[2];

    assign hsel[0]   = hsel_drv && (dut_sel == 1'b0);
    assign hsel[1]   = hsel_drv && (dut_sel == 1'b1);
    assign hready[0] = hreadyout[0] && !force_low;
    assign hready[1] = hreadyout[1] && !force_low;

    ahb_dm_slave #(.ADDR_WORDS_BITS(14), .WAIT_STATES(1)) dut_a (
        .HCLK(HCLK), .rst(rst), .HSEL(hsel[0]), .HTRANS(HTRANS), .HADDR(HADDR),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hready[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]),
        .SRAM_CS(sram_cs[0]), .SRAM_WE(sram_we[0]), .SRAM_A(sram_a[0]),
        .SRAM_DI(sram_di[0]), .SRAM_DO(sram_do[0])
    );

    ahb_dm_slave #(.ADDR_WORDS_BITS(14), .WAIT_STATES(0)) dut_b (
        .HCLK(HCLK), .rst(rst), .HSEL(hsel[1]), .HTRANS(HTRANS), .HADDR(HADDR),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hready[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]),
        .SRAM_CS(sram_cs[1]), .SRAM_WE(sram_we[1]), .SRAM_A(sram_a[1]),
        .SRAM_DI(sram_di[1]), .SRAM_DO(sram_do[1])
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Synchronous single-port SRAM macros: read data one cycle after strobe.
    always @(posedge HCLK) begin
        if (sram_cs[0]) begin
            if (sram_we[0]) sram0[sram_a[0]] <= sram_di[0];
            else            sram_do[0]       <= sram0[sram_a[0]];
        end
        if (sram_cs[1]) begin
            if (sram_we[1]) sram1[sram_a[1]] <= sram_di[1];
            else            sram_do[1]       <= sram1[sram_a[1]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic int wsOf(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] mkAddr(input int idx, input int low);
        logic [11:0] hi;
        hi = 12'($urandom);
        return {4'h2, hi, 14'(idx), 2'(low)};
    endfunction

    // Issue one address phase (called just after a rising edge). Real
    // transfers push their expected response and are held until accepted.
    task automatic applyStimulus(input int k, input logic sel, input logic [1:0] trans,
                                 input logic [31:0] addr, input logic write, input logic [31:0] wdata);
        exp_t e;
        int   key;
        int   ws;
        logic ok;
        int   guard;
        dut_sel  = 1'(k);
        hsel_drv = sel;
        HTRANS   = trans;
        HADDR    = addr;
        HWRITE   = write;
        if (sel && trans[1]) begin
            ws    = wsOf(k);
            key   = k * 65536 + int'(addr[15:2]);
            e.idx = addr[15:2];
            if (addr[1:0] != 2'b00) begin
                e.kind = 2; e.data = 32'd0; e.len = 2;
            end else if (write) begin
                e.kind = 0; e.data = wdata; e.len = ws + 1;
                ref_mem[key] = wdata;
            end else begin
                e.kind = 1;
                e.data = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
                e.len  = ((ws < 1) ? 1 : ws) + 1;
            end
            if (k == 0) q0.push_back(e); else q1.push_back(e);
            ok = 1'b0;
            guard = 0;
            while (!ok && guard < 20) begin
                @(negedge HCLK);
                ok = hready[k];
                @(posedge HCLK);
                #1;
                guard++;
            end
            checkOutput("accepted", 32'(ok), 32'd1);
            HWDATA = write ? wdata : $urandom;
        end else begin
            @(posedge HCLK);
            #1;
        end
        hsel_drv = 1'b0;
        HTRANS   = 2'b00;
    endtask

    // Observe one cycle of instance k at the falling edge.
    task automatic monitorStep(input int k);
        if (in_phase[k]) begin
            cyc[k]++;
            checkOutput($sformatf("hresp%0d", k), 32'(hresp[k]), (cur[k].kind == 2) ? 32'd1 : 32'd0);
            if (sram_cs[k]) begin
                if (sram_we[k]) begin
                    wr_seen[k]++; wr_a[k] = sram_a[k]; wr_d[k] = sram_di[k]; wr_c[k] = cyc[k];
                end else begin
                    rd_seen[k]++; rd_a[k] = sram_a[k]; rd_c[k] = cyc[k];
                end
            end
            if (hreadyout[k]) begin
                checkOutput($sformatf("len%0d", k), 32'(cyc[k]), 32'(cur[k].len));
                case (cur[k].kind)
                    0: begin
                        checkOutput("wr_strobes", 32'(wr_seen[k]), 32'd1);
                        checkOutput("wr_no_read", 32'(rd_seen[k]), 32'd0);
                        checkOutput("wr_addr", 32'(wr_a[k]), 32'(cur[k].idx));
                        checkOutput("wr_data", wr_d[k], cur[k].data);
                        checkOutput("wr_in_last", 32'(wr_c[k]), 32'(cyc[k]));
                    end
                    1: begin
                        checkOutput("rd_strobes", 32'(rd_seen[k]), 32'd1);
                        checkOutput("rd_no_write", 32'(wr_seen[k]), 32'd0);
                        checkOutput("rd_addr", 32'(rd_a[k]), 32'(cur[k].idx));
                        checkOutput("rd_strobe_cycle", 32'(rd_c[k]), 32'(cyc[k] - 1));
                        checkOutput("rd_data", hrdata[k], cur[k].data);
                    end
                    default: begin
                        checkOutput("err_no_sram", 32'(wr_seen[k] + rd_seen[k]), 32'd0);
                    end
                endcase
                in_phase[k] = 1'b0;
            end else begin
                checkOutput("wait_hrdata", hrdata[k], 32'd0);
                if (cyc[k] > 12) begin
                    checkOutput("phase_timeout", 32'(cyc[k]), 32'(cur[k].len));
                    in_phase[k] = 1'b0;
                end
            end
        end else begin
            checkOutput($sformatf("idle_ready%0d", k), 32'(hreadyout[k]), 32'd1);
            checkOutput($sformatf("idle_resp%0d", k), 32'(hresp[k]), 32'd0);
            checkOutput($sformatf("idle_cs%0d", k), 32'(sram_cs[k]), 32'd0);
            checkOutput($sformatf("idle_hrdata%0d", k), hrdata[k], 32'd0);
        end
        if (hsel[k] && HTRANS[1] && hready[k]) begin
            n_checks++;
            if ((k == 0 && q0.size() > 0) || (k == 1 && q1.size() > 0)) begin
                n_pass++;
                cur[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
            end else begin
                $display("[TB] FAIL unexpected_transfer: dut %0d accepted with no expectation queued", k);
            end
            in_phase[k] = 1'b1;
            cyc[k] = 0; wr_seen[k] = 0; rd_seen[k] = 0;
        end
    endtask

    // Scoreboard monitor. While reset is asserted, any data phase in flight
    // is abandoned, and it must not have written the SRAM.
    always @(negedge HCLK) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                if (in_phase[k]) begin
                    checkOutput("abort_no_write", 32'(wr_seen[k]), 32'd0);
                    in_phase[k] = 1'b0;
                end
            end else begin
                monitorStep(k);
            end
        end
    end

    task automatic checkResetOutputs(input int k);
        checkOutput("rst_hreadyout", 32'(hreadyout[k]), 32'd1);
        checkOutput("rst_hresp", 32'(hresp[k]), 32'd0);
        checkOutput("rst_hrdata", hrdata[k], 32'd0);
        checkOutput("rst_cs", 32'(sram_cs[k]), 32'd0);
        checkOutput("rst_we", 32'(sram_we[k]), 32'd0);
        checkOutput("rst_a", 32'(sram_a[k]), 32'd0);
        checkOutput("rst_di", sram_di[k], 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int r;
        int idx;
        n_checks = 0; n_pass = 0;
        in_phase[0] = 1'b0; in_phase[1] = 1'b0;
        rst = 1'b1; hsel_drv = 1'b0; dut_sel = 1'b0; force_low = 1'b0;
        HTRANS = 2'b00; HADDR = 32'd0; HWRITE = 1'b0; HWDATA = 32'd0;
        repeat (2) @(posedge HCLK);
        #1;
        checkResetOutputs(0);
        checkResetOutputs(1);
        rst = 1'b0;
        @(posedge HCLK); #1;

        $display("[TB] directed tests, WAIT_STATES=1");
        applyStimulus(0, 1, 2'b10, 32'h2000_0010, 1, 32'hDEAD_BEEF);
        applyStimulus(0, 1, 2'b10, 32'h2000_0010, 0, 32'h0);
        applyStimulus(0, 1, 2'b10, 32'h2000_0000, 1, 32'h11);
        applyStimulus(0, 1, 2'b11, 32'h2000_0004, 1, 32'h22);
        applyStimulus(0, 1, 2'b11, 32'h2000_0008, 1, 32'h33);
        applyStimulus(0, 1, 2'b10, 32'h2000_0000, 0, 32'h0);
        applyStimulus(0, 1, 2'b11, 32'h2000_0004, 0, 32'h0);
        applyStimulus(0, 1, 2'b11, 32'h2000_0008, 0, 32'h0);
        applyStimulus(0, 1, 2'b10, 32'h2000_0002, 0, 32'h0);
        repeat (3) @(posedge HCLK);
        #1;

        // Non-transfers: IDLE, BUSY, unselected, and NONSEQ while HREADY is low.
        applyStimulus(0, 1, 2'b00, 32'h2000_0010, 1, 32'h0);
        applyStimulus(0, 1, 2'b01, 32'h2000_0010, 1, 32'h0);
        applyStimulus(0, 0, 2'b10, 32'h2000_0010, 1, 32'h0);
        checkOutput("nontransfer_ready", 32'(hreadyout[0]), 32'd1);
        dut_sel = 1'b0; hsel_drv = 1'b1; HTRANS = 2'b10; HADDR = 32'h2000_0014;
        HWRITE = 1'b1; force_low = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        checkOutput("hready_low_ready", 32'(hreadyout[0]), 32'd1);
        checkOutput("hready_low_cs", 32'(sram_cs[0]), 32'd0);
        hsel_drv = 1'b0; HTRANS = 2'b00; force_low = 1'b0;
        @(posedge HCLK); #1;

        $display("[TB] directed tests, WAIT_STATES=0");
        applyStimulus(1, 1, 2'b10, 32'h2000_0020, 1, 32'hA5A5_0001);
        applyStimulus(1, 1, 2'b10, 32'h2000_0020, 0, 32'h0);
        repeat (3) @(posedge HCLK);
        #1;

        $display("[TB] random traffic");
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                applyStimulus(k, 1, 2'b10, mkAddr(i, 0), 1, $urandom);
            end
            for (int n = 0; n < 60; n++) begin
                r   = $urandom_range(0, 9);
                idx = $urandom_range(0, 15);
                if (r < 4)
                    applyStimulus(k, 1, {1'b1, 1'($urandom)}, mkAddr(idx, 0), 1, $urandom);
                else if (r < 8)
                    applyStimulus(k, 1, {1'b1, 1'($urandom)}, mkAddr(idx, 0), 0, 32'h0);
                else if (r == 8)
                    applyStimulus(k, 1, 2'b10, mkAddr(idx, $urandom_range(1, 3)), 1'($urandom), $urandom);
                else
                    applyStimulus(k, 1'($urandom), {1'b0, 1'($urandom)}, mkAddr(idx, 0), 1, $urandom);
            end
            repeat (4) @(posedge HCLK);
            #1;
        end
        checkOutput("q0_drained", 32'(q0.size()), 32'd0);
        checkOutput("q1_drained", 32'(q1.size()), 32'd0);

        $display("[TB] reset during a write data phase");
        applyStimulus(0, 1, 2'b10, 32'h2000_0030, 1, 32'hCAFE_F00D);
        checkOutput("abort_in_wait", 32'(hreadyout[0]), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        checkResetOutputs(0);
        @(posedge HCLK); #1;
        rst = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        checkOutput("abort_we_low", 32'(sram_we[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
